conv_job_scheduler: RTL
=======================

// Module: conv_job_scheduler
// PURPOSE
//  Queues convolution job descriptors written by the CPU over MMIO and sequences the conv accelerator one job at a time.
//  For each job it loads the conv_* configuration and pulses conv_start, then waits for conv_done.
//  It also drives dmem_sel, which hands the shared dual-port dmem to the accelerator for the whole job.
//  Sits between the CPU MMIO decode, conv_block, and the dmem port mux.
// PARAMETERS
//  FIFO_DEPTH  4   job descriptor slots; power of two, >= 2
//  CNT_W       3   occupancy counter width, = log2(FIFO_DEPTH)+1
// PORTS
//  clk             in   1    system clock
//  rst             in   1    synchronous, active-high reset
//  cfg_we          in   1    MMIO write strobe, one cycle per write
//  cfg_addr        in   3    MMIO word index: 0 FM_DIM, 1 WT, 2 IFM, 3 OFM, 4 PUSH, 5 STATUS, 6 DONE_CNT
//  cfg_wdata       in   32   MMIO write data
//  cfg_rdata       out  32   MMIO read data; combinational from cfg_addr
//  conv_idle       in   1    accelerator idle
//  conv_done       in   1    accelerator done, one-cycle pulse
//  conv_start      out  1    one-cycle start pulse
//  conv_fm_dim     out  32   feature-map dimension, held stable for the job
//  conv_wt_offset  out  32   weight base address, held stable for the job
//  conv_ifm_offset out  32   input feature-map base address, held stable for the job
//  conv_ofm_offset out  32   output feature-map base address, held stable for the job
//  dmem_sel        out  1    1: dmem ports routed to conv_block; 0: routed to CPU
//  sched_irq       out  1    one-cycle pulse when a job completes and the queue is empty
// BEHAVIOUR
//  Reset values
//   - conv_start=0, dmem_sel=0, sched_irq=0, all conv_* config outputs=0.
//   - FIFO empty, staging registers=0, DONE_CNT=0, overflow=0, FSM in IDLE.
//  MMIO writes
//   - Indices 0-3 write the staging registers.
//   - PUSH (any data) enqueues {FM_DIM,WT,IFM,OFM} staging as one 128-bit entry.
//   - A PUSH while count==FIFO_DEPTH is dropped and sets sticky overflow.
//   - Fullness is judged on the pre-cycle count, even if a pop happens in the same cycle.
//   - A write to STATUS clears overflow. A write to DONE_CNT clears DONE_CNT.
//   - Staging registers are not cleared by PUSH.
//  MMIO reads
//   - 0-3: staging registers.
//   - 5: STATUS = {overflow[8], conv_idle[7], busy[6], full[5], empty[4], count[3:0]}, zero-extended.
//     busy = FSM != IDLE.
//   - 6: DONE_CNT, 32-bit, wraps at 2^32.
//   - 4 and 7 read 0.
//  FSM: IDLE -> LOAD -> START -> RUN -> RELEASE -> IDLE
//   - IDLE: if !empty && conv_idle, go to LOAD.
//   - LOAD: latch FIFO head into the conv_* outputs, pop, set dmem_sel=1.
//   - START: conv_start=1 for exactly this cycle.
//   - RUN: hold; go to RELEASE on conv_done.
//   - RELEASE: dmem_sel=0, DONE_CNT+=1, sched_irq=1 iff FIFO empty. Next state IDLE.
//  Latency
//   - A PUSH into an empty queue with conv_idle=1 is written at edge N.
//   - LOAD occupies cycle N+1; conv_start is high in cycle N+2; dmem_sel is high from N+2.
//   - Back-to-back jobs: 3 cycles between conv_done and the next conv_start (RELEASE, IDLE, LOAD).
//  Boundaries
//   - conv_done outside RUN is ignored.
//   - conv_idle=0 in IDLE defers launch indefinitely.
//   - PUSH while a job runs is accepted if not full. PUSH and pop in the same cycle: count unchanged.
//   - DONE_CNT clear in the same cycle as an increment: the clear wins.
//   - rst mid-job: immediate return to reset values. FIFO flushed, dmem_sel drops next cycle.
//     conv_block shares rst, so it is reset together with the scheduler.
//   - conv_* outputs keep the last job's values after RELEASE until the next LOAD.
// STRUCTURE
//  conv_sched_pkg
//   - MMIO word-index constants, STATUS bit positions, FSM state enum (3-bit).
//   - Job descriptor width constant (128).
//  Sub-module conv_job_fifo
//   - Synchronous FIFO, 128-bit x FIFO_DEPTH; push/pop/full/empty/count.
//   - Wrapping read and write pointers.
//  Top level
//   - FSM, staging registers, MMIO decode, counters.
// TESTING
//  1. After reset: all outputs 0. STATUS reads 0x90 with conv_idle=1 (empty and conv_idle set).
//  2. Stage 8 / 0x100 / 0x200 / 0x400, then PUSH at N.
//     conv_start is high only in N+2 with conv_fm_dim=8, conv_ofm_offset=0x400, and dmem_sel=1.
//     conv_done 50 cycles later: dmem_sel=0 next cycle, sched_irq pulses, DONE_CNT=1.
//  3. Five PUSHes with conv_idle=0 and FIFO_DEPTH=4: count=4, full=1, overflow=1.
//     Write STATUS: overflow=0. Release conv_idle: jobs run in push order, DONE_CNT ends at 4.
//  4. Two queued jobs: exactly 3 cycles from the first conv_done to the second conv_start.
//     sched_irq fires only after the second job.
//  5. conv_done pulse while in IDLE: no state change, DONE_CNT unchanged.
//     DONE_CNT clear coincident with RELEASE: reads 0.
//  6. rst asserted during RUN with 2 jobs queued: next cycle dmem_sel=0, STATUS.empty=1, FSM IDLE.
//     No conv_start until a new PUSH.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// Shared constants and types for the convolution job scheduler: MMIO map, STATUS layout,
// FSM encoding and the job descriptor.
package conv_sched_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned JOB_W  = 4 * WORD_W;

   localparam logic [2:0] ADDR_FM_DIM   = 3'd0;
   localparam logic [2:0] ADDR_WT       = 3'd1;
   localparam logic [2:0] ADDR_IFM      = 3'd2;
   localparam logic [2:0] ADDR_OFM      = 3'd3;
   localparam logic [2:0] ADDR_PUSH     = 3'd4;
   localparam logic [2:0] ADDR_STATUS   = 3'd5;
   localparam logic [2:0] ADDR_DONE_CNT = 3'd6;

   localparam int unsigned ST_OVERFLOW = 8;
   localparam int unsigned ST_IDLE     = 7;
   localparam int unsigned ST_BUSY     = 6;
   localparam int unsigned ST_FULL     = 5;
   localparam int unsigned ST_EMPTY    = 4;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_START   = 3'd2;
   localparam logic [2:0] S_RUN     = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;

   typedef struct packed {
      logic [WORD_W-1:0] fm_dim;
      logic [WORD_W-1:0] wt_offset;
      logic [WORD_W-1:0] ifm_offset;
      logic [WORD_W-1:0] ofm_offset;
   } job_t;

endpackage

// File: rtl/conv_job_fifo.sv
// Synchronous job-descriptor FIFO with wrapping pointers; a push when full or a pop when
// empty is ignored.
module conv_job_fifo
   import conv_sched_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  job_t             wdata,
   output job_t             rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [JOB_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = job_t'(mem[rd_ptr]);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/conv_job_scheduler.sv
// Queues MMIO-written conv job descriptors and runs the conv accelerator one job at a time,
// owning the dmem port mux for the duration of each job.
module conv_job_scheduler
   import conv_sched_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_we,
   input  logic [2:0]  cfg_addr,
   input  logic [31:0] cfg_wdata,
   output logic [31:0] cfg_rdata,
   input  logic        conv_idle,
   input  logic        conv_done,
   output logic        conv_start,
   output logic [31:0] conv_fm_dim,
   output logic [31:0] conv_wt_offset,
   output logic [31:0] conv_ifm_offset,
   output logic [31:0] conv_ofm_offset,
   output logic        dmem_sel,
   output logic        sched_irq
);

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   job_t             stage;
   job_t             head;
   logic [31:0]      done_cnt;
   logic             overflow;
   logic             push_req_c;
   logic             pop_c;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic [31:0]      status_c;

   assign push_req_c = cfg_we && (cfg_addr == ADDR_PUSH);
   assign pop_c      = (state == S_LOAD);

   conv_job_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req_c),
      .pop   (pop_c),
      .wdata (stage),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (!fifo_empty && conv_idle) state_nxt = S_LOAD;
         S_LOAD:    state_nxt = S_START;
         S_START:   state_nxt = S_RUN;
         S_RUN:     if (conv_done) state_nxt = S_RELEASE;
         S_RELEASE: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Job outputs are registered on the transition so they line up with the FSM timeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         stage           <= '0;
         done_cnt        <= '0;
         overflow        <= 1'b0;
         conv_start      <= 1'b0;
         conv_fm_dim     <= '0;
         conv_wt_offset  <= '0;
         conv_ifm_offset <= '0;
         conv_ofm_offset <= '0;
         dmem_sel        <= 1'b0;
         sched_irq       <= 1'b0;
      end else begin
         state      <= state_nxt;
         conv_start <= (state == S_LOAD);
         sched_irq  <= (state == S_RELEASE) && fifo_empty;
         if (cfg_we) begin
            case (cfg_addr)
               ADDR_FM_DIM: stage.fm_dim     <= cfg_wdata;
               ADDR_WT:     stage.wt_offset  <= cfg_wdata;
               ADDR_IFM:    stage.ifm_offset <= cfg_wdata;
               ADDR_OFM:    stage.ofm_offset <= cfg_wdata;
               ADDR_STATUS: overflow         <= 1'b0;
               default:     ;
            endcase
         end
         if (push_req_c && fifo_full) overflow <= 1'b1;
         // A software clear beats the completion increment.
         if (cfg_we && (cfg_addr == ADDR_DONE_CNT)) done_cnt <= '0;
         else if (state == S_RELEASE)               done_cnt <= done_cnt + 32'd1;
         if (state == S_LOAD) begin
            conv_fm_dim     <= head.fm_dim;
            conv_wt_offset  <= head.wt_offset;
            conv_ifm_offset <= head.ifm_offset;
            conv_ofm_offset <= head.ofm_offset;
            dmem_sel        <= 1'b1;
         end
         if ((state == S_RUN) && conv_done) dmem_sel <= 1'b0;
      end
   end

   always_comb begin
      status_c              = '0;
      status_c[ST_OVERFLOW] = overflow;
      status_c[ST_IDLE]     = conv_idle;
      status_c[ST_BUSY]     = (state != S_IDLE);
      status_c[ST_FULL]     = fifo_full;
      status_c[ST_EMPTY]    = fifo_empty;
      status_c[3:0]         = 4'(fifo_count);
   end

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         ADDR_FM_DIM:   cfg_rdata = stage.fm_dim;
         ADDR_WT:       cfg_rdata = stage.wt_offset;
         ADDR_IFM:      cfg_rdata = stage.ifm_offset;
         ADDR_OFM:      cfg_rdata = stage.ofm_offset;
         ADDR_STATUS:   cfg_rdata = status_c;
         ADDR_DONE_CNT: cfg_rdata = done_cnt;
         default:       cfg_rdata = '0;
      endcase
   end

endmodule
